// File: rtl/reqack_responder_pkg.sv
// rtl/reqack_responder_pkg.sv - shared types and helpers for the req/ack target-side responder
package reqack_responder_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Wait counter sticks at all-ones so a long stall never wraps back into range.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/reqack_responder_sync.sv
// rtl/reqack_responder_sync.sv - two-flop synchronizer for the incoming req toggle
module reqack_responder_sync (
    input  logic clk,
    input  logic reset_l,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reqack_responder.sv
// rtl/reqack_responder.sv - target-domain responder: syncs req toggle, runs one local memory access, flips ack
module reqack_responder
    import reqack_responder_pkg::*;
#(
    parameter int          DATAWIDTH = 32,
    parameter int          ADDRWIDTH = 20,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 req,
    input  logic [ADDRWIDTH-1:0] req_addr,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic                 rd_wr_l,
    output logic                 ack,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic                 mem_req,
    output logic                 mem_rd_wr_l,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [DATAWIDTH-1:0] mem_wr_data,
    input  logic [DATAWIDTH-1:0] mem_rd_data,
    input  logic                 mem_rdy,
    output logic                 timeout_err
);

    localparam logic [DATAWIDTH-1:0] ERR_VAL = ERR_DATA[DATAWIDTH-1:0];
    localparam logic [CNT_W-1:0]     TO_VAL  = 16'(TIMEOUT);

    state_t           state;
    state_t           next_state;
    logic             req_synced;
    logic             req_seen;
    logic             pending;
    logic [CNT_W-1:0] wait_cnt;

    logic capture;
    logic issue;
    logic rdy_done;
    logic to_done;
    logic flip_ack;

    reqack_responder_sync u_req_sync (
        .clk     (clk),
        .reset_l (reset_l),
        .d       (req),
        .q       (req_synced)
    );

    // A toggle arriving while busy simply stays pending until the next IDLE.
    assign pending = (req_synced != req_seen);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        issue      = 1'b0;
        rdy_done   = 1'b0;
        to_done    = 1'b0;
        flip_ack   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    capture    = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue      = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                // mem_rdy takes priority over a coincident timeout.
                if (mem_rdy) begin
                    rdy_done   = 1'b1;
                    next_state = ST_DONE;
                end else if ((TIMEOUT != 0) && (wait_cnt == TO_VAL)) begin
                    to_done    = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                flip_ack   = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            req_seen    <= 1'b0;
            ack         <= 1'b0;
            rd_data     <= '0;
            mem_req     <= 1'b0;
            mem_rd_wr_l <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            timeout_err <= to_done;
            if (capture) begin
                req_seen    <= req_synced;
                mem_addr    <= req_addr;
                mem_wr_data <= wr_data;
                mem_rd_wr_l <= rd_wr_l;
            end
            if (issue) begin
                mem_req  <= 1'b1;
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= sat_inc(wait_cnt);
            end
            if (rdy_done || to_done) begin
                mem_req <= 1'b0;
            end
            // rd_data settles one edge ahead of the ack flip.
            if (rdy_done && mem_rd_wr_l) begin
                rd_data <= mem_rd_data;
            end else if (to_done && mem_rd_wr_l) begin
                rd_data <= ERR_VAL;
            end
            if (flip_ack) begin
                ack <= ~ack;
            end
        end
    end

endmodule

// File: tb/tb_reqack_responder.sv
// tb/tb_reqack_responder.sv - directed-vector bench for reqack_responder
module tb_reqack_responder;

    logic        clk;
    logic        reset_l;
    logic        req;
    logic [19:0] req_addr;
    logic [31:0] wr_data;
    logic        rd_wr_l;
    logic        ack;
    logic [31:0] rd_data;
    logic        mem_req;
    logic        mem_rd_wr_l;
    logic [19:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_rdy;
    logic        timeout_err;

    logic        model_rdy;
    logic        stray_rdy;
    logic [31:0] rd_val;
    int          rdy_delay;
    int          wait_cnt;
    logic        in_acc;
    int          to_pulses;
    logic [19:0] log_addr[$];
    logic        log_rw[$];
    logic [31:0] log_wd[$];

    int errs;
    int checks;

    typedef struct {
        logic [19:0] addr;
        logic [31:0] wdata;
        logic        rw;
        int          dly;
        logic [31:0] rval;
        logic [31:0] exp_rd;
        int          exp_to;
    } vec_t;

    vec_t vecs[8];

    assign mem_rdy     = model_rdy | stray_rdy;
    assign mem_rd_data = rd_val;

    reqack_responder #(
        .DATAWIDTH (32),
        .ADDRWIDTH (20),
        .TIMEOUT   (8),
        .ERR_DATA  (32'hDEADBEEF)
    ) dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .req         (req),
        .req_addr    (req_addr),
        .wr_data     (wr_data),
        .rd_wr_l     (rd_wr_l),
        .ack         (ack),
        .rd_data     (rd_data),
        .mem_req     (mem_req),
        .mem_rd_wr_l (mem_rd_wr_l),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_rdy     (mem_rdy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: logs each access when mem_req rises, pulses mem_rdy after rdy_delay cycles (0 = never).
    initial begin
        model_rdy = 1'b0;
        in_acc    = 1'b0;
        wait_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            model_rdy = 1'b0;
            if (!mem_req) begin
                in_acc = 1'b0;
            end else begin
                if (!in_acc) begin
                    in_acc   = 1'b1;
                    wait_cnt = 0;
                    log_addr.push_back(mem_addr);
                    log_rw.push_back(mem_rd_wr_l);
                    log_wd.push_back(mem_wr_data);
                end
                wait_cnt++;
                if (rdy_delay != 0 && wait_cnt == rdy_delay) model_rdy = 1'b1;
            end
        end
    end

    initial begin
        to_pulses = 0;
        forever begin
            @(negedge clk);
            if (timeout_err) to_pulses++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_txn(input logic [19:0] a, input logic [31:0] wd, input logic rw,
                          input int dly, input logic [31:0] rv, output int lat);
        logic prev;
        req_addr  = a;
        wr_data   = wd;
        rd_wr_l   = rw;
        rdy_delay = dly;
        rd_val    = rv;
        prev      = ack;
        req       = ~req;
        lat       = 0;
        while (ack == prev && lat < 60) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_rd_wr_l"}, 32'(mem_rd_wr_l), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        logic        exp_ack;
        logic [31:0] cur_rd;
        int          lat;
        int          n0;
        int          t0;
        int          k;
        int          flips;
        logic        prev;

        errs      = 0;
        checks    = 0;
        reset_l   = 1'b0;
        req       = 1'b0;
        req_addr  = '0;
        wr_data   = '0;
        rd_wr_l   = 1'b0;
        rdy_delay = 0;
        rd_val    = '0;
        stray_rdy = 1'b0;
        exp_ack   = 1'b0;
        cur_rd    = '0;

        vecs[0] = '{20'h00104, 32'h0,        1'b1, 3, 32'h12345678, 32'h12345678, 0};
        vecs[1] = '{20'h00200, 32'hA5A5A5A5, 1'b0, 1, 32'h0,        32'h12345678, 0};
        vecs[2] = '{20'h0FFFC, 32'h0,        1'b1, 1, 32'h00000001, 32'h00000001, 0};
        vecs[3] = '{20'h00010, 32'h0,        1'b1, 0, 32'h0,        32'hDEADBEEF, 1};
        vecs[4] = '{20'h00020, 32'h0F0F0F0F, 1'b0, 0, 32'h0,        32'hDEADBEEF, 1};
        vecs[5] = '{20'h00030, 32'h0,        1'b1, 9, 32'hCAFEF00D, 32'hCAFEF00D, 0};
        vecs[6] = '{20'hFFFFC, 32'h0,        1'b1, 8, 32'h0BADF00D, 32'h0BADF00D, 0};
        vecs[7] = '{20'h00008, 32'h00000000, 1'b0, 2, 32'h0,        32'h0BADF00D, 0};

        tick(3);
        check_reset_outputs("in_reset");
        reset_l = 1'b1;
        tick(5);
        chk("post_reset_mem_req", 32'(mem_req), 32'd0);
        chk("post_reset_accesses", 32'(log_addr.size()), 32'd0);

        // Vector table: latency is 5+N for a normal completion, timeout completes after TIMEOUT+1 wait cycles.
        for (int i = 0; i < 8; i++) begin
            n0 = log_addr.size();
            t0 = to_pulses;
            do_txn(vecs[i].addr, vecs[i].wdata, vecs[i].rw, vecs[i].dly, vecs[i].rval, lat);
            exp_ack = ~exp_ack;
            chk($sformatf("v%0d_ack", i), 32'(ack), 32'(exp_ack));
            if (vecs[i].exp_to != 0)
                chk($sformatf("v%0d_latency", i), 32'(lat), 32'd14);
            else
                chk($sformatf("v%0d_latency", i), 32'(lat), 32'(5 + vecs[i].dly));
            chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].exp_rd);
            tick(2);
            chk($sformatf("v%0d_timeout_pulses", i), 32'(to_pulses - t0), 32'(vecs[i].exp_to));
            chk($sformatf("v%0d_accesses", i), 32'(log_addr.size() - n0), 32'd1);
            if (log_addr.size() > n0) begin
                chk($sformatf("v%0d_mem_addr", i), 32'(log_addr[n0]), 32'(vecs[i].addr));
                chk($sformatf("v%0d_mem_rd_wr_l", i), 32'(log_rw[n0]), 32'(vecs[i].rw));
                if (!vecs[i].rw)
                    chk($sformatf("v%0d_mem_wr_data", i), log_wd[n0], vecs[i].wdata);
            end
            chk($sformatf("v%0d_mem_req_idle", i), 32'(mem_req), 32'd0);
            cur_rd = vecs[i].exp_rd;
        end

        // mem_rdy outside WAIT must be ignored.
        rd_val    = 32'h55555555;
        stray_rdy = 1'b1;
        tick(1);
        stray_rdy = 1'b0;
        tick(3);
        chk("stray_rdy_rd_data", rd_data, cur_rd);
        chk("stray_rdy_ack", 32'(ack), 32'(exp_ack));

        // Back-to-back: second toggle lands while the first access is in WAIT.
        n0        = log_addr.size();
        req_addr  = 20'h00100;
        rd_wr_l   = 1'b1;
        rdy_delay = 4;
        rd_val    = 32'h11112222;
        prev      = ack;
        req       = ~req;
        k         = 0;
        while (!mem_req && k < 20) begin
            tick(1);
            k++;
        end
        chk("b2b_first_mem_req_seen", 32'(mem_req), 32'd1);
        req_addr = 20'h00300;
        wr_data  = 32'h33334444;
        rd_wr_l  = 1'b0;
        req      = ~req;
        flips    = 0;
        k        = 0;
        while (flips < 2 && k < 80) begin
            tick(1);
            k++;
            if (ack != prev) begin
                flips++;
                prev = ack;
            end
        end
        tick(3);
        chk("b2b_ack_flips", 32'(flips), 32'd2);
        chk("b2b_ack_level", 32'(ack), 32'(exp_ack));
        chk("b2b_accesses", 32'(log_addr.size() - n0), 32'd2);
        if (log_addr.size() >= n0 + 2) begin
            chk("b2b_addr0", 32'(log_addr[n0]), 32'h00100);
            chk("b2b_rw0", 32'(log_rw[n0]), 32'd1);
            chk("b2b_addr1", 32'(log_addr[n0 + 1]), 32'h00300);
            chk("b2b_rw1", 32'(log_rw[n0 + 1]), 32'd0);
            chk("b2b_wd1", log_wd[n0 + 1], 32'h33334444);
        end
        cur_rd = 32'h11112222;
        chk("b2b_rd_data", rd_data, cur_rd);

        // Random directed mix, no timeouts.
        for (int i = 0; i < 20; i++) begin
            logic [19:0] a;
            logic [31:0] wd;
            logic [31:0] rv;
            logic        rw;
            int          dly;
            a   = 20'($urandom) & 20'hFFFFC;
            wd  = $urandom;
            rv  = $urandom;
            rw  = 1'($urandom_range(0, 1));
            dly = $urandom_range(1, 6);
            n0  = log_addr.size();
            do_txn(a, wd, rw, dly, rv, lat);
            exp_ack = ~exp_ack;
            if (rw) cur_rd = rv;
            chk($sformatf("r%0d_ack", i), 32'(ack), 32'(exp_ack));
            chk($sformatf("r%0d_latency", i), 32'(lat), 32'(5 + dly));
            chk($sformatf("r%0d_rd_data", i), rd_data, cur_rd);
            if (log_addr.size() > n0)
                chk($sformatf("r%0d_mem_addr", i), 32'(log_addr[n0]), 32'(a));
            else
                chk($sformatf("r%0d_accesses", i), 32'(log_addr.size() - n0), 32'd1);
            tick(1);
        end

        // Reset while the access is stalled in WAIT.
        req_addr  = 20'h00440;
        rd_wr_l   = 1'b1;
        rdy_delay = 0;
        req       = ~req;
        k         = 0;
        while (!mem_req && k < 20) begin
            tick(1);
            k++;
        end
        chk("rst_mid_wait_mem_req_seen", 32'(mem_req), 32'd1);
        tick(2);
        reset_l = 1'b0;
        req     = 1'b0;
        tick(1);
        check_reset_outputs("rst_mid_wait");
        n0      = log_addr.size();
        reset_l = 1'b1;
        tick(20);
        chk("rst_release_accesses", 32'(log_addr.size() - n0), 32'd0);
        chk("rst_release_ack", 32'(ack), 32'd0);
        exp_ack = 1'b0;

        do_txn(20'h00500, 32'h0, 1'b1, 2, 32'h77778888, lat);
        exp_ack = ~exp_ack;
        chk("recover_ack", 32'(ack), 32'(exp_ack));
        chk("recover_rd_data", rd_data, 32'h77778888);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
